// File: rtl/boot_loader.sv
// Boot loader: wakes the SPI flash, streams a program image in mode 0 and writes it
// word by word into Hack instruction RAM, holding the CPU in reset until the last word lands.
module boot_loader #(
    parameter logic [23:0] FLASH_ADDR  = 24'h010000,
    parameter int          WORDS       = 4096,
    parameter int          CLK_DIV     = 1,
    parameter int          WAKE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sdo,
    output logic        spi_sdi,
    output logic        spi_sck,
    output logic        spi_csx,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        cpu_reset,
    output logic        done
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAKE_CYCLES - 1);
    localparam logic [15:0]       LAST_WORD = 16'(WORDS - 1);
    localparam logic [31:0]       WAKE_WORD = {8'hAB, 24'h000000};
    localparam logic [31:0]       READ_WORD = {8'h03, FLASH_ADDR};

    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        READ_CMD,
        READ_DATA,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [4:0]        bit_reg, bit_next;
    logic [31:0]       tx_reg, tx_next;
    logic [14:0]       rx_reg, rx_next;
    logic [15:0]       idx_reg, idx_next;
    logic              sck_reg, sck_next;
    logic              csx_reg, csx_next;
    logic              we_reg, we_next;
    logic [15:0]       addr_reg, addr_next;
    logic [15:0]       data_reg, data_next;
    logic              cpu_rst_reg, cpu_rst_next;
    logic              done_reg, done_next;

    logic       tick;
    logic [4:0] cmd_last;

    // One half SCK period has elapsed.
    assign tick     = (div_reg == DIV_LAST);
    assign cmd_last = (state_reg == WAKE_CMD) ? 5'd7 : 5'd31;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= WAKE_CMD;
            div_reg     <= '0;
            wait_reg    <= '0;
            bit_reg     <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            idx_reg     <= '0;
            sck_reg     <= 1'b0;
            csx_reg     <= 1'b1;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            cpu_rst_reg <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            wait_reg    <= wait_next;
            bit_reg     <= bit_next;
            tx_reg      <= tx_next;
            rx_reg      <= rx_next;
            idx_reg     <= idx_next;
            sck_reg     <= sck_next;
            csx_reg     <= csx_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            cpu_rst_reg <= cpu_rst_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        wait_next    = wait_reg;
        bit_next     = bit_reg;
        tx_next      = tx_reg;
        rx_next      = rx_reg;
        idx_next     = idx_reg;
        sck_next     = sck_reg;
        csx_next     = csx_reg;
        we_next      = 1'b0;
        addr_next    = addr_reg;
        data_next    = data_reg;
        cpu_rst_next = cpu_rst_reg;
        done_next    = done_reg;

        case (state_reg)
            WAKE_CMD, READ_CMD: begin
                if (csx_reg) begin
                    // Only reachable right after reset: open the wake transfer.
                    csx_next = 1'b0;
                    sck_next = 1'b0;
                    div_next = '0;
                    bit_next = '0;
                    tx_next  = WAKE_WORD;
                end else if (!tick) begin
                    div_next = div_reg + 1'b1;
                end else begin
                    div_next = '0;
                    if (!sck_reg) begin
                        sck_next = 1'b1;
                    end else begin
                        sck_next = 1'b0;
                        if (bit_reg == cmd_last) begin
                            bit_next = '0;
                            tx_next  = '0;
                            if (state_reg == WAKE_CMD) begin
                                csx_next   = 1'b1;
                                wait_next  = '0;
                                state_next = WAKE_WAIT;
                            end else begin
                                state_next = READ_DATA;
                            end
                        end else begin
                            bit_next = bit_reg + 5'd1;
                            tx_next  = {tx_reg[30:0], 1'b0};
                        end
                    end
                end
            end

            WAKE_WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    // Chip select falls with the first read-command bit already on SDI.
                    state_next = READ_CMD;
                    csx_next   = 1'b0;
                    sck_next   = 1'b0;
                    div_next   = '0;
                    bit_next   = '0;
                    tx_next    = READ_WORD;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end

            READ_DATA: begin
                if (!tick) begin
                    div_next = div_reg + 1'b1;
                end else begin
                    div_next = '0;
                    if (!sck_reg) begin
                        sck_next = 1'b1;
                        rx_next  = {rx_reg[13:0], spi_sdo};
                        if (bit_reg == 5'd15) begin
                            bit_next  = '0;
                            we_next   = 1'b1;
                            addr_next = idx_reg;
                            data_next = {rx_reg, spi_sdo};
                            if (idx_reg == LAST_WORD) begin
                                state_next = DONE;
                            end else begin
                                idx_next = idx_reg + 16'd1;
                            end
                        end else begin
                            bit_next = bit_reg + 5'd1;
                        end
                    end else begin
                        sck_next = 1'b0;
                    end
                end
            end

            DONE: begin
                csx_next     = 1'b1;
                sck_next     = 1'b0;
                tx_next      = '0;
                done_next    = 1'b1;
                cpu_rst_next = 1'b0;
            end

            default: begin
                state_next = WAKE_CMD;
            end
        endcase
    end

    // SDI is the MSB of the command shifter; it is all zeros outside command phases.
    assign spi_sdi   = tx_reg[31];
    assign spi_sck   = sck_reg;
    assign spi_csx   = csx_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_data  = data_reg;
    assign cpu_reset = cpu_rst_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: two instances (CLK_DIV 1 and 3) each talking to a behavioural
// SPI flash; strobes are checked against words built directly from the flash image.
`timescale 1ns/1ps
module tb_boot_loader;
    localparam int          NW    = 8;
    localparam logic [23:0] FADDR = 24'h010000;
    localparam int          WAKE  = 64;
    localparam logic [63:0] RST_VEC = {26'd0, 6'b100010, 32'd0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        sdi     [2];
    logic        sck     [2];
    logic        csx     [2];
    logic        we      [2];
    logic        cpu_rst [2];
    logic        dn      [2];
    logic [15:0] addr    [2];
    logic [15:0] data    [2];
    logic [7:0]  img     [2][2*NW];
    int          divs    [2] = '{1, 3};

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int D = (gi == 0) ? 1 : 3;
        logic        fl_sdo = 1'b0;
        int          fl_bits = 0;
        logic [31:0] fl_cmd = '0;
        int          tr_n = 0;
        logic [31:0] tr_cmd [8];
        int          tr_bits [8];
        int          per_viol = 0;
        int          setup_viol = 0;
        int          csx_viol = 0;
        time         last_pos = 0;
        time         last_sdi = 0;
        bit          have_pos = 1'b0;
        logic        p_sck = 1'b0;
        logic        p_csx = 1'b1;
        logic        p_sdi = 1'b0;
        int          dbit;

        boot_loader #(
            .FLASH_ADDR (FADDR),
            .WORDS      (NW),
            .CLK_DIV    (D),
            .WAKE_CYCLES(WAKE)
        ) u_dut (
            .clk      (clk),
            .reset    (rst[gi]),
            .spi_sdo  (fl_sdo),
            .spi_sdi  (sdi[gi]),
            .spi_sck  (sck[gi]),
            .spi_csx  (csx[gi]),
            .mem_we   (we[gi]),
            .mem_addr (addr[gi]),
            .mem_data (data[gi]),
            .cpu_reset(cpu_rst[gi]),
            .done     (dn[gi])
        );

        // Flash model and SPI protocol watcher in one process.
        always @(sck[gi] or csx[gi] or sdi[gi]) begin
            if (sdi[gi] !== p_sdi) last_sdi = $time;
            if (csx[gi] === 1'b1 && p_csx !== 1'b1) begin
                if (fl_bits > 0 && tr_n < 8) begin
                    tr_cmd[tr_n]  = fl_cmd;
                    tr_bits[tr_n] = fl_bits;
                    tr_n++;
                end
                fl_bits  = 0;
                fl_cmd   = '0;
                have_pos = 1'b0;
            end
            if (sck[gi] === 1'b1 && p_sck !== 1'b1) begin
                if (csx[gi] !== 1'b0) begin
                    csx_viol++;
                end else begin
                    if (have_pos && ($time - last_pos != 2 * D * 10)) per_viol++;
                    if ($time - last_sdi < D * 10) setup_viol++;
                    have_pos = 1'b1;
                    last_pos = $time;
                    if (fl_bits < 32) fl_cmd = {fl_cmd[30:0], sdi[gi]};
                    fl_bits++;
                end
            end
            if (sck[gi] === 1'b0 && p_sck === 1'b1 && csx[gi] === 1'b0 &&
                fl_bits >= 32 && fl_cmd[31:24] == 8'h03) begin
                dbit   = fl_bits - 32;
                fl_sdo = img[gi][(dbit / 8) % (2 * NW)][7 - (dbit % 8)];
            end
            p_sck = sck[gi];
            p_csx = csx[gi];
            p_sdi = sdi[gi];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outvec(input int g);
        return {26'd0, csx[g], sck[g], sdi[g], we[g], cpu_rst[g], dn[g], addr[g], data[g]};
    endfunction

    task automatic check_tr(input int cnt, input logic [31:0] c0, input logic [31:0] c1,
                            input int b0, input int b1);
        chk("tr_count", cnt, 2);
        chk("wake_bits", b0, 8);
        chk("wake_cmd", c0, 32'h000000AB);
        chk("read_cmd", c1, {8'h03, FADDR});
        chk("read_bits", b1, 32 + 16 * NW);
    endtask

    task automatic run_load(input int g, input int abort_at);
        int          idx = 0;
        int          cyc = 0;
        int          last = 0;
        int          falls = 0;
        int          hi = 0;
        int          lat = -1;
        int          hold_bad = 0;
        logic [15:0] last_a = '0;
        logic [15:0] last_d = '0;
        logic        prev_csx = 1'b1;
        logic        prev_we = 1'b0;
        bit          fin = 1'b0;
        while (!fin && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (prev_csx && !csx[g]) begin
                falls++;
                if (falls == 1) lat = cyc;
            end
            if (falls == 1 && csx[g]) hi++;
            if (prev_we) chk("we_pulse", we[g], 0);
            if (idx == NW) begin
                chk("done_state", {dn[g], cpu_rst[g], csx[g], we[g]}, 4'b1010);
                fin = 1'b1;
            end else if (we[g] && !prev_we) begin
                $display("dut%0d strobe addr=%04h data=%04h cyc=%0d", g, addr[g], data[g], cyc);
                chk("addr", addr[g], idx);
                chk("data", data[g], {img[g][2*idx], img[g][2*idx+1]});
                chk("busy", {dn[g], cpu_rst[g]}, 2'b01);
                if (idx > 0) chk("gap", cyc - last, 32 * divs[g]);
                last   = cyc;
                last_a = 16'(idx);
                last_d = {img[g][2*idx], img[g][2*idx+1]};
                idx++;
                if (idx - 1 == abort_at) begin
                    @(posedge clk);
                    #1 rst[g] = 1'b1;
                    #1;
                    chk("abort_rst", outvec(g), RST_VEC);
                    fin = 1'b1;
                end
            end else if (!we[g] && {addr[g], data[g]} !== {last_a, last_d}) begin
                hold_bad++;
            end
            prev_csx = csx[g];
            prev_we  = we[g];
        end
        chk("finished", fin, 1);
        chk("csx_lat", (lat >= 1 && lat <= 2 * divs[g]), 1);
        chk("wake_high", hi, WAKE);
        chk("hold", hold_bad, 0);
    endtask

    initial begin
        int b;
        int q;
        logic [7:0] fixed [8];
        fixed = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF};
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 2 * NW; i++)
                img[g][i] = 8'($urandom);
        for (int i = 0; i < 8; i++) img[0][i] = fixed[i];

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) chk("reset_vals", outvec(g), RST_VEC);

        // First load on the fast instance, aborted right after word 1.
        @(negedge clk);
        rst[0] = 1'b0;
        run_load(0, 1);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        chk("reset_hold", outvec(0), RST_VEC);

        // Full reload after the mid-load reset.
        b = g_dut[0].tr_n;
        rst[0] = 1'b0;
        run_load(0, -1);
        check_tr(g_dut[0].tr_n - b, g_dut[0].tr_cmd[b], g_dut[0].tr_cmd[b+1],
                 g_dut[0].tr_bits[b], g_dut[0].tr_bits[b+1]);

        q = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (we[0] !== 1'b0 || sck[0] !== 1'b0 || csx[0] !== 1'b1 ||
                dn[0] !== 1'b1 || cpu_rst[0] !== 1'b0) q++;
        end
        chk("quiet", q, 0);

        // Divided-clock instance with a fully random image.
        b = g_dut[1].tr_n;
        @(negedge clk);
        rst[1] = 1'b0;
        run_load(1, -1);
        check_tr(g_dut[1].tr_n - b, g_dut[1].tr_cmd[b], g_dut[1].tr_cmd[b+1],
                 g_dut[1].tr_bits[b], g_dut[1].tr_bits[b+1]);

        chk("sck_period0", g_dut[0].per_viol, 0);
        chk("sck_period1", g_dut[1].per_viol, 0);
        chk("sdi_setup0", g_dut[0].setup_viol, 0);
        chk("sdi_setup1", g_dut[1].setup_viol, 0);
        chk("sck_csx0", g_dut[0].csx_viol, 0);
        chk("sck_csx1", g_dut[1].csx_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits directly upstream of the Hack instruction memory and the CPU.
- After reset, streams a Hack program image from the board SPI flash over SPI mode 0 and writes it word by word into instruction RAM, starting at address 0.
- Holds the CPU in reset for the whole load and releases it when the last word is written.

Parameters:
- FLASH_ADDR, 24'h010000, byte address in flash of the first image byte.
- WORDS, 4096, number of 16-bit words to load (1..65536).
- CLK_DIV, 1, clk cycles per SCK half-period (SCK = clk/(2*CLK_DIV)), minimum 1.
- WAKE_CYCLES, 64, clk cycles with CSX high after the 0xAB wake command, before the read command.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- spi_sdo  in  1  flash data out (MISO).
- spi_sdi  out  1  flash data in (MOSI).
- spi_sck  out  1  SPI clock; idles low.
- spi_csx  out  1  flash chip select, active low.
- mem_we  out  1  one-cycle write strobe to instruction RAM.
- mem_addr  out  16  instruction RAM word address.
- mem_data  out  16  instruction word to write.
- cpu_reset  out  1  held high until the load completes.
- done  out  1  high once the load is complete.

Behaviour:
- Reset values (applied asynchronously while reset=1): spi_csx=1, spi_sck=0, spi_sdi=0, mem_we=0, mem_addr=0, mem_data=0, cpu_reset=1, done=0; state=WAKE_CMD; all counters 0.
- SPI framing: mode 0, MSB first.
  - spi_sdi changes only while SCK is low (on the falling edge, or at CSX assertion for the first bit).
  - spi_sdo is sampled on each SCK rising edge.
  - Each bit takes 2*CLK_DIV clk cycles.
- State WAKE_CMD: drive CSX low, shift out 0xAB (8 bits). Then drive CSX high and SCK low.
- State WAKE_WAIT: count WAKE_CYCLES clk cycles with CSX high.
- State READ_CMD: drive CSX low, shift out 0x03 followed by FLASH_ADDR[23:0] (32 bits total).
  - spi_sdi is don't-care afterwards; drive it 0.
- State READ_DATA: CSX stays low and SCK keeps running. Each 16 sampled bits form one word.
  - Byte order: the first flash byte is word[15:8], the second is word[7:0].
  - On the clk cycle after the 16th bit of a word is sampled: mem_we=1 for exactly one cycle, mem_addr = word index, mem_data = word.
  - mem_addr and mem_data hold their values until the next strobe.
  - The word index starts at 0 and increments after each strobe.
- Termination: after the strobe for index WORDS-1, go to DONE. With WORDS=65536, the last write is at 0xFFFF; the index never wraps to 0.
- State DONE: CSX=1, SCK=0, SDI=0, mem_we=0, cpu_reset=0, done=1.
  - cpu_reset deasserts on the same cycle done rises: one cycle after the final mem_we pulse.
  - DONE is terminal until reset. No further SCK edges or strobes.
- Reset mid-operation (any state): all outputs return to reset values immediately, CSX deasserts, and the sequence restarts from WAKE_CMD at index 0 once reset falls.
- No data checking: the flash contents are taken as-is; an all-ones (erased) image is loaded unchanged.
- Exactly one state drives SPI at a time. SCK never toggles while CSX is high.

Test Plan:
- Reset values: assert reset, then check all outputs equal the reset values. Release reset: within 2*CLK_DIV cycles CSX falls and SDI carries 0xAB over 8 SCK cycles; CSX then rises and stays high for 64 clk.
- Read command: FLASH_ADDR=24'h010000. Bits on SDI after the second CSX fall decode to 03 01 00 00 (32 rising edges).
- Data load: WORDS=4, CLK_DIV=1, flash model returns 12 34 AB CD 00 00 FF FF. Required strobes: (0,1234), (1,ABCD), (2,0000), (3,FFFF), each mem_we high exactly 1 cycle, 32 clk apart. The cycle after the last strobe: done=1, cpu_reset=0, CSX=1.
- Divider: CLK_DIV=3. SCK period is 6 clk, SDI is stable across every rising edge, and the word strobe spacing is 96 clk.
- Mid-load reset: assert reset one cycle after the strobe for index 1. Outputs return to reset values in the same cycle. After release, the sequence replays from 0xAB, and the first new strobe is (0,1234).
- Post-done quiescence: after done, run 1000 clk. No mem_we pulses, SCK stays 0, CSX stays 1, done stays 1.
